// File: rtl/sum_latch_pkg.sv
// rtl/sum_latch_pkg.sv - shared widths, ASCII constants and state encoding for sum_latch_ctrl
package sum_latch_pkg;

  localparam int OPERAND_W = 4;
  localparam int SUM_W     = 5;
  localparam int BYTE_W    = 8;

  localparam logic [BYTE_W-1:0] ASCII_ZERO    = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_UPPER_A = 8'h41;
  localparam logic [BYTE_W-1:0] ASCII_LOWER_A = 8'h61;

  // SEND is the raw-mode result state; SEND_HI/SEND_LO carry the two ASCII characters.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_ADD,
    ST_SEND,
    ST_SEND_HI,
    ST_SEND_LO
  } state_t;

endpackage

// File: rtl/hex_ascii_codec.sv
// rtl/hex_ascii_codec.sv - combinational nibble to uppercase hex ASCII encoder and hex ASCII to nibble decoder
module hex_ascii_codec
  import sum_latch_pkg::*;
(
  input  logic [OPERAND_W-1:0] enc_nibble,
  output logic [BYTE_W-1:0]    enc_char,
  input  logic [BYTE_W-1:0]    dec_char,
  output logic [OPERAND_W-1:0] dec_nibble,
  output logic                 dec_valid
);

  always_comb begin
    if (enc_nibble < 4'd10) begin
      enc_char = ASCII_ZERO + {4'h0, enc_nibble};
    end else begin
      enc_char = ASCII_UPPER_A + {4'h0, enc_nibble - 4'd10};
    end
  end

  // Digits sit at 0x30..0x39 and letters at 0x41/0x61 upward, so the low nibble plus 9 gives 10..15.
  always_comb begin
    dec_valid  = 1'b0;
    dec_nibble = '0;
    if (dec_char >= ASCII_ZERO && dec_char <= ASCII_ZERO + 8'd9) begin
      dec_valid  = 1'b1;
      dec_nibble = dec_char[3:0];
    end else if ((dec_char >= ASCII_UPPER_A && dec_char <= ASCII_UPPER_A + 8'd5) ||
                 (dec_char >= ASCII_LOWER_A && dec_char <= ASCII_LOWER_A + 8'd5)) begin
      dec_valid  = 1'b1;
      dec_nibble = dec_char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/sum_latch_ctrl.sv
// rtl/sum_latch_ctrl.sv - UART-to-adder sequencer; define SUMLATCH_ASCII_EN for hex ASCII operands and results
module sum_latch_ctrl
  import sum_latch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [OPERAND_W-1:0] add_a,
  output logic [OPERAND_W-1:0] add_b,
  input  logic [SUM_W-1:0]     add_sum,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [SUM_W-1:0]     sum_latched,
  output logic                 busy,
  output logic                 rx_drop
);

  state_t                 state;
  state_t                 state_nxt;
  logic                   op_valid;
  logic [OPERAND_W-1:0]   op_nibble;
  logic                   drop_now;

`ifdef SUMLATCH_ASCII_EN
  logic [BYTE_W-1:0]      lo_char;
  logic [OPERAND_W-1:0]   dec_nibble;
  logic                   dec_valid;

  hex_ascii_codec u_codec (
    .enc_nibble (sum_latched[OPERAND_W-1:0]),
    .enc_char   (lo_char),
    .dec_char   (rx_data),
    .dec_nibble (dec_nibble),
    .dec_valid  (dec_valid)
  );

  // Non-hex bytes never count as operands, so separators pass through IDLE/WAIT_B silently.
  assign op_valid  = rx_valid & dec_valid;
  assign op_nibble = dec_nibble;
`else
  logic unused_rx_hi;

  assign unused_rx_hi = ^rx_data[BYTE_W-1:OPERAND_W];
  assign op_valid     = rx_valid;
  assign op_nibble    = rx_data[OPERAND_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (op_valid) state_nxt = ST_WAIT_B;
      ST_WAIT_B:  if (op_valid) state_nxt = ST_ADD;
`ifdef SUMLATCH_ASCII_EN
      ST_ADD:     state_nxt = ST_SEND_HI;
`else
      ST_ADD:     state_nxt = ST_SEND;
`endif
      ST_SEND:    if (tx_ready) state_nxt = ST_IDLE;
      ST_SEND_HI: if (tx_ready) state_nxt = ST_SEND_LO;
      ST_SEND_LO: if (tx_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    drop_now = rx_valid && (state == ST_ADD || state == ST_SEND ||
                            state == ST_SEND_HI || state == ST_SEND_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a       <= '0;
      add_b       <= '0;
      sum_latched <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      rx_drop <= drop_now;
      case (state)
        ST_IDLE:   if (op_valid) add_a <= op_nibble;
        ST_WAIT_B: if (op_valid) add_b <= op_nibble;
        ST_ADD: begin
          sum_latched <= add_sum;
          tx_valid    <= 1'b1;
`ifdef SUMLATCH_ASCII_EN
          tx_data     <= add_sum[SUM_W-1] ? ASCII_ZERO + 8'd1 : ASCII_ZERO;
`else
          tx_data     <= {3'b000, add_sum};
`endif
        end
        ST_SEND:   if (tx_ready) tx_valid <= 1'b0;
`ifdef SUMLATCH_ASCII_EN
        // tx_valid stays high so the low digit is offered straight after the high one.
        ST_SEND_HI: if (tx_ready) tx_data <= lo_char;
        ST_SEND_LO: if (tx_ready) tx_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_latch_ctrl.sv
// tb/tb_sum_latch_ctrl.sv - scoreboard bench for sum_latch_ctrl, raw mode or SUMLATCH_ASCII_EN
module tb_sum_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [4:0] add_sum;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] sum_latched;
  logic       busy;
  logic       rx_drop;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  sum_latch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sum     (add_sum),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .sum_latched (sum_latched),
    .busy        (busy),
    .rx_drop     (rx_drop)
  );

  always #5 clk = ~clk;

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      if (rx_drop) drop_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] opb(input logic [3:0] n);
`ifdef SUMLATCH_ASCII_EN
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h57 + {4'h0, n};
`else
    return {4'h0, n};
`endif
  endfunction

  function automatic logic [7:0] first_byte(input logic [4:0] s);
`ifdef SUMLATCH_ASCII_EN
    return s[4] ? 8'h31 : 8'h30;
`else
    return {3'b000, s};
`endif
  endfunction

  task automatic push_exp(input logic [4:0] s);
`ifdef SUMLATCH_ASCII_EN
    logic [3:0] lo;
    lo = s[3:0];
    exp_q.push_back(s[4] ? 8'h31 : 8'h30);
    exp_q.push_back(lo < 4'd10 ? 8'h30 + {4'h0, lo} : 8'h37 + {4'h0, lo});
`else
    exp_q.push_back({3'b000, s});
`endif
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({add_a, add_b, sum_latched, tx_data, rx_drop} !== 22'h0)
      begin bad++; $display("FAIL reset_regs got=%h/%h/%h/%h/%b want=0", add_a, add_b, sum_latched, tx_data, rx_drop); end
    pulse_rx(opb(4'd3));
    pulse_rx(opb(4'd9));
    @(posedge clk); #1;
    total++; if (tx_valid !== 1'b1 || sum_latched !== 5'd12)
      begin bad++; $display("FAIL reset_presend got=%b/%0d want=1/12", tx_valid, sum_latched); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || sum_latched !== 5'd0 || add_a !== 4'd0)
      begin bad++; $display("FAIL reset_midsend got=%b/%b/%0d/%0d want=0/0/0/0", tx_valid, busy, sum_latched, add_a); end
    rst = 1'b0;
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reset_no_tx got=%0d want=0", obs_q.size()); end
    obs_q.delete(); exp_q.delete(); drop_cnt = 0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] e, o;
    tx_ready = 1'b1;
    push_exp(5'd7);
    pulse_rx(opb(4'd5));
    pulse_rx(opb(4'd2));
    total++; if (add_a !== 4'd5 || add_b !== 4'd2 || tx_valid !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL basic_add_state got=%0d/%0d/%b/%b want=5/2/0/1", add_a, add_b, tx_valid, busy); end
    @(posedge clk); #1;
    total++; if (tx_valid !== 1'b1 || tx_data !== first_byte(5'd7) || sum_latched !== 5'd7)
      begin bad++; $display("FAIL basic_latency got=%b/%h/%0d want=1/%h/7", tx_valid, tx_data, sum_latched, first_byte(5'd7)); end
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_byte got=%h want=%h", o, e); end
    end
    total++; if (busy !== 1'b0 || add_a !== 4'd5 || add_b !== 4'd2)
      begin bad++; $display("FAIL basic_idle got=%b/%0d/%0d want=0/5/2", busy, add_a, add_b); end
    exp_q.delete(); obs_q.delete();
  endtask

`ifndef SUMLATCH_ASCII_EN
  task automatic test_upper_nibble();
    bit ok;
    logic [7:0] e, o;
    tx_ready = 1'b1;
    push_exp(5'd16);
    pulse_rx(8'hF8);
    pulse_rx(8'h08);
    @(posedge clk); #1;
    total++; if (add_a !== 4'd8 || sum_latched !== 5'd16)
      begin bad++; $display("FAIL upper_nibble got=%0d/%0d want=8/16", add_a, sum_latched); end
    wait_tx(exp_q.size(), ok);
    total++; if (!ok || obs_q.size() != 1) begin bad++; $display("FAIL upper_count got=%0d want=1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL upper_byte got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coincide();
    bit ok;
    int d0;
    logic [7:0] e, o;
    tx_ready = 1'b1;
    d0 = drop_cnt;
    push_exp(5'd0);
    push_exp(5'd7);
    pulse_rx(opb(4'd0));
    pulse_rx(opb(4'd0));
    @(posedge clk); #1;
    // Strobe on the accept edge is dropped; the one right after it starts a new transaction.
    rx_valid = 1'b1; rx_data = opb(4'd6);
    @(posedge clk); #1;
    rx_data = opb(4'd3);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    pulse_rx(opb(4'd4));
    wait_tx(exp_q.size(), ok);
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL coincide_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (add_a !== 4'd3 || add_b !== 4'd4 || sum_latched !== 5'd7)
      begin bad++; $display("FAIL coincide_regs got=%0d/%0d/%0d want=3/4/7", add_a, add_b, sum_latched); end
    total++; if (!ok || obs_q.size() != 2) begin bad++; $display("FAIL coincide_count got=%0d want=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL coincide_byte got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  task automatic test_stall();
    bit ok;
    bit stable;
    int d0;
    logic [7:0] e, o;
    tx_ready = 1'b0;
    d0 = drop_cnt;
    push_exp(5'd16);
    pulse_rx(opb(4'd9));
    pulse_rx(opb(4'd7));
    @(posedge clk); #1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_valid = (i == 3);
      rx_data  = (i == 3) ? opb(4'd1) : 8'h00;
      @(posedge clk); #1;
      if (tx_valid !== 1'b1 || tx_data !== first_byte(5'd16)) stable = 1'b0;
    end
    rx_valid = 1'b0;
    total++; if (!stable) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/%h", tx_valid, tx_data, first_byte(5'd16)); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL stall_early got=%0d want=0", obs_q.size()); end
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL stall_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (add_a !== 4'd9 || add_b !== 4'd7 || sum_latched !== 5'd16)
      begin bad++; $display("FAIL stall_regs got=%0d/%0d/%0d want=9/7/16", add_a, add_b, sum_latched); end
    tx_ready = 1'b1;
    wait_tx(exp_q.size(), ok);
    total++; if (!ok || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL stall_byte got=%h want=%h", o, e); end
    end
    total++; if (sum_latched !== 5'd16 || busy !== 1'b0) begin bad++; $display("FAIL stall_after got=%0d/%b want=16/0", sum_latched, busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0;
    logic [7:0] e, o;
    tx_ready = 1'b1;
    d0 = drop_cnt;
    push_exp(5'd30);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = opb(4'd15);
    @(posedge clk); #1;
    rx_data = opb(4'd15);
    @(posedge clk); #1;
    rx_data = opb(4'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_tx(exp_q.size(), ok);
    total++; if (add_a !== 4'd15 || add_b !== 4'd15 || sum_latched !== 5'd30)
      begin bad++; $display("FAIL b2b_regs got=%0d/%0d/%0d want=15/15/30", add_a, add_b, sum_latched); end
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL b2b_drop got=%0d want=1", drop_cnt - d0); end
    total++; if (!ok || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL b2b_byte got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef SUMLATCH_ASCII_EN
  task automatic test_ascii_filter();
    bit ok;
    int d0;
    logic [7:0] e, o;
    tx_ready = 1'b1;
    d0 = drop_cnt;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h45);
    pulse_rx(8'h0D);
    pulse_rx(8'h61);
    pulse_rx(8'h20);
    pulse_rx(8'h34);
    total++; if (add_a !== 4'd10 || add_b !== 4'd4)
      begin bad++; $display("FAIL ascii_operands got=%0d/%0d want=10/4", add_a, add_b); end
    wait_tx(exp_q.size(), ok);
    total++; if (drop_cnt != d0) begin bad++; $display("FAIL ascii_nodrop got=%0d want=0", drop_cnt - d0); end
    total++; if (!ok || obs_q.size() != 2) begin bad++; $display("FAIL ascii_count got=%0d want=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL ascii_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ascii_toggle();
    logic [7:0] e, o;
    tx_ready = 1'b0;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h30);
    pulse_rx(8'h38);
    pulse_rx(8'h38);
    for (int i = 0; i < 20; i++) begin
      tx_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    total++; if (obs_q.size() != 2 || busy !== 1'b0)
      begin bad++; $display("FAIL toggle_count got=%0d/%b want=2/0", obs_q.size(), busy); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL toggle_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifndef SUMLATCH_ASCII_EN
    test_upper_nibble();
    test_coincide();
`endif
    test_stall();
    test_back_to_back();
`ifdef SUMLATCH_ASCII_EN
    test_ascii_filter();
    test_ascii_toggle();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
